// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: pass-through for ALU results, byte/half/word
// loads and stores over a ready/valid data-memory port, misalignment and timeout traps.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ex_valid,
  input  logic [5:0]  ex_opcode,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_regwrite,
  output logic        exc_misaligned,
  output logic        exc_buserr,
  output logic [31:0] exc_addr
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [7:0] TMO    = TIMEOUT[7:0];

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [4:0]  rd_q, rd_d;
  logic        regwrite_q, regwrite_d;
  logic        mem_req_valid_q, mem_req_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic        exc_mis_q, exc_mis_d;
  logic        exc_bus_q, exc_bus_d;
  logic [31:0] exc_addr_q, exc_addr_d;

  logic        is_load, is_store, misaligned, op_is_store;
  logic [7:0]  cnt_inc;
  logic [31:0] shifted, load_val;

  always_comb begin
    is_load    = (ex_opcode == OP_LB) || (ex_opcode == OP_LH) || (ex_opcode == OP_LW) ||
                 (ex_opcode == OP_LBU) || (ex_opcode == OP_LHU);
    is_store   = (ex_opcode == OP_SB) || (ex_opcode == OP_SH) || (ex_opcode == OP_SW);
    misaligned = (((ex_opcode == OP_LH) || (ex_opcode == OP_LHU) || (ex_opcode == OP_SH)) &&
                  ex_alu_out[0]) ||
                 (((ex_opcode == OP_LW) || (ex_opcode == OP_SW)) && (ex_alu_out[1:0] != 2'b00));
    op_is_store = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);
    cnt_inc    = cnt_q + 8'd1;
    // Shift the selected lane down to bit 0; halves only use offsets 0 and 2.
    shifted    = mem_rdata >> {addr_q[1:0], 3'b000};
    case (op_q)
      OP_LB:   load_val = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  load_val = {24'd0, shifted[7:0]};
      OP_LH:   load_val = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  load_val = {16'd0, shifted[15:0]};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    op_d            = op_q;
    addr_d          = addr_q;
    rd_d            = rd_q;
    regwrite_d      = regwrite_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_addr_d      = mem_addr_q;
    mem_we_d        = mem_we_q;
    mem_wdata_d     = mem_wdata_q;
    wb_valid_d      = 1'b0;
    wb_data_d       = wb_data_q;
    wb_rd_d         = wb_rd_q;
    wb_regwrite_d   = 1'b0;
    exc_mis_d       = 1'b0;
    exc_bus_d       = 1'b0;
    exc_addr_d      = exc_addr_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          wb_rd_d = ex_rd;
          if ((is_load || is_store) && misaligned) begin
            wb_valid_d = 1'b1;
            wb_data_d  = '0;
            exc_mis_d  = 1'b1;
            exc_addr_d = ex_alu_out;
          end else if (is_load || is_store) begin
            state_d         = S_REQ;
            op_d            = ex_opcode;
            addr_d          = ex_alu_out;
            rd_d            = ex_rd;
            regwrite_d      = ex_regwrite;
            mem_req_valid_d = 1'b1;
            mem_addr_d      = {ex_alu_out[31:2], 2'b00};
            case (ex_opcode)
              OP_SB: begin
                mem_we_d    = 4'b0001 << ex_alu_out[1:0];
                mem_wdata_d = {4{ex_store_data[7:0]}};
              end
              OP_SH: begin
                mem_we_d    = ex_alu_out[1] ? 4'b1100 : 4'b0011;
                mem_wdata_d = {2{ex_store_data[15:0]}};
              end
              OP_SW: begin
                mem_we_d    = 4'b1111;
                mem_wdata_d = ex_store_data;
              end
              default: begin
                mem_we_d    = 4'b0000;
                mem_wdata_d = ex_store_data;
              end
            endcase
          end else begin
            wb_valid_d    = 1'b1;
            wb_data_d     = ex_alu_out;
            wb_regwrite_d = ex_regwrite;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          if (op_is_store) begin
            state_d    = S_IDLE;
            wb_valid_d = 1'b1;
            wb_data_d  = '0;
            wb_rd_d    = rd_q;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        // A response on the final counted cycle still completes normally.
        if (mem_resp_valid) begin
          state_d       = S_IDLE;
          wb_valid_d    = 1'b1;
          wb_data_d     = load_val;
          wb_rd_d       = rd_q;
          wb_regwrite_d = regwrite_q;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO) begin
            state_d    = S_IDLE;
            wb_valid_d = 1'b1;
            wb_data_d  = '0;
            wb_rd_d    = rd_q;
            exc_bus_d  = 1'b1;
            exc_addr_d = addr_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      op_q            <= '0;
      addr_q          <= '0;
      rd_q            <= '0;
      regwrite_q      <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_we_q        <= '0;
      mem_wdata_q     <= '0;
      wb_valid_q      <= 1'b0;
      wb_data_q       <= '0;
      wb_rd_q         <= '0;
      wb_regwrite_q   <= 1'b0;
      exc_mis_q       <= 1'b0;
      exc_bus_q       <= 1'b0;
      exc_addr_q      <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      op_q            <= op_d;
      addr_q          <= addr_d;
      rd_q            <= rd_d;
      regwrite_q      <= regwrite_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      mem_we_q        <= mem_we_d;
      mem_wdata_q     <= mem_wdata_d;
      wb_valid_q      <= wb_valid_d;
      wb_data_q       <= wb_data_d;
      wb_rd_q         <= wb_rd_d;
      wb_regwrite_q   <= wb_regwrite_d;
      exc_mis_q       <= exc_mis_d;
      exc_bus_q       <= exc_bus_d;
      exc_addr_q      <= exc_addr_d;
    end
  end

  assign stall          = (state_q != S_IDLE);
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_addr       = mem_addr_q;
  assign mem_we         = mem_we_q;
  assign mem_wdata      = mem_wdata_q;
  assign wb_valid       = wb_valid_q;
  assign wb_data        = wb_data_q;
  assign wb_rd          = wb_rd_q;
  assign wb_regwrite    = wb_regwrite_q;
  assign exc_misaligned = exc_mis_q;
  assign exc_buserr     = exc_bus_q;
  assign exc_addr       = exc_addr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: pass-through, loads, stores, misalignment,
// timeout, and reset during an outstanding load.
module tb_mem_stage_lsu;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        ex_valid;
  logic [5:0]  ex_opcode;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
  logic        exc_misaligned;
  logic        exc_buserr;
  logic [31:0] exc_addr;

  int unsigned passed = 0;
  int unsigned total  = 0;

  mem_stage_lsu #(.TIMEOUT(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_alu_out(ex_alu_out),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .exc_misaligned(exc_misaligned), .exc_buserr(exc_buserr), .exc_addr(exc_addr)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] rd, input logic rw);
    ex_valid = 1'b1; ex_opcode = op; ex_alu_out = a;
    ex_store_data = sd; ex_rd = rd; ex_regwrite = rw;
    step();
    ex_valid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; ex_valid = 1'b0; ex_opcode = '0; ex_alu_out = '0;
    ex_store_data = '0; ex_rd = '0; ex_regwrite = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    step(); step();
    chk("rst_stall",  32'(stall), 32'd0);
    chk("rst_wbv",    32'(wb_valid), 32'd0);
    chk("rst_reqv",   32'(mem_req_valid), 32'd0);
    chk("rst_exc",    exc_addr, 32'd0);
    chk("rst_we",     32'(mem_we), 32'd0);
    Reset = 1'b0;
    step();

    // Pass-through RTYPE
    issue(6'h00, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    chk("rt_wbv",   32'(wb_valid), 32'd1);
    chk("rt_data",  wb_data, 32'h0000_1234);
    chk("rt_rd",    32'(wb_rd), 32'd5);
    chk("rt_rw",    32'(wb_regwrite), 32'd1);
    chk("rt_stall", 32'(stall), 32'd0);
    step();
    chk("rt_pulse", 32'(wb_valid), 32'd0);

    // LB at 0x103, response on the 4th WAIT cycle (counter would hit TIMEOUT then)
    issue(6'h20, 32'h0000_0103, 32'h0, 5'd7, 1'b1);
    chk("lb_stall", 32'(stall), 32'd1);
    chk("lb_reqv",  32'(mem_req_valid), 32'd1);
    chk("lb_addr",  mem_addr, 32'h0000_0100);
    chk("lb_we",    32'(mem_we), 32'd0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("lb_reqv_off", 32'(mem_req_valid), 32'd0);
    step(); step(); step();
    chk("lb_wait_stall", 32'(stall), 32'd1);
    chk("lb_no_bus",     32'(exc_buserr), 32'd0);
    mem_resp_valid = 1'b1; mem_rdata = 32'h80FF_7F01;
    step();
    mem_resp_valid = 1'b0;
    chk("lb_wbv",   32'(wb_valid), 32'd1);
    chk("lb_data",  wb_data, 32'hFFFF_FF80);
    chk("lb_rd",    32'(wb_rd), 32'd7);
    chk("lb_rw",    32'(wb_regwrite), 32'd1);
    chk("lb_bus",   32'(exc_buserr), 32'd0);
    chk("lb_stall_end", 32'(stall), 32'd0);

    // LBU same address, immediate response
    issue(6'h24, 32'h0000_0103, 32'h0, 5'd8, 1'b1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    chk("lbu_data", wb_data, 32'h0000_0080);

    // LH / LHU upper half at 0x102 -> 0x80FF
    issue(6'h21, 32'h0000_0102, 32'h0, 5'd9, 1'b1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    chk("lh_data", wb_data, 32'hFFFF_80FF);
    issue(6'h25, 32'h0000_0100, 32'h0, 5'd9, 1'b1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    chk("lhu_data", wb_data, 32'h0000_7F01);

    // SH upper half with two cycles of backpressure
    issue(6'h29, 32'h0000_0202, 32'h0000_BEEF, 5'd0, 1'b0);
    chk("sh_addr0",  mem_addr, 32'h0000_0200);
    chk("sh_we0",    32'(mem_we), 32'hC);
    chk("sh_wd0",    mem_wdata, 32'hBEEF_BEEF);
    step();
    chk("sh_reqv1",  32'(mem_req_valid), 32'd1);
    chk("sh_addr1",  mem_addr, 32'h0000_0200);
    chk("sh_we1",    32'(mem_we), 32'hC);
    chk("sh_wd1",    mem_wdata, 32'hBEEF_BEEF);
    step();
    chk("sh_reqv2",  32'(mem_req_valid), 32'd1);
    chk("sh_wd2",    mem_wdata, 32'hBEEF_BEEF);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("sh_wbv",    32'(wb_valid), 32'd1);
    chk("sh_rw",     32'(wb_regwrite), 32'd0);
    chk("sh_stall",  32'(stall), 32'd0);
    chk("sh_reqoff", 32'(mem_req_valid), 32'd0);

    // SB lane 1 and SW full word
    issue(6'h28, 32'h0000_0301, 32'h1234_56A5, 5'd0, 1'b0);
    chk("sb_we", 32'(mem_we), 32'h2);
    chk("sb_wd", mem_wdata, 32'hA5A5_A5A5);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    issue(6'h2b, 32'h0000_0400, 32'hCAFE_F00D, 5'd0, 1'b0);
    chk("sw_we", 32'(mem_we), 32'hF);
    chk("sw_wd", mem_wdata, 32'hCAFE_F00D);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("sw_wbv", 32'(wb_valid), 32'd1);

    // Misaligned LW
    issue(6'h23, 32'h0000_0006, 32'h0, 5'd3, 1'b1);
    chk("mis_exc",   32'(exc_misaligned), 32'd1);
    chk("mis_addr",  exc_addr, 32'h0000_0006);
    chk("mis_wbv",   32'(wb_valid), 32'd1);
    chk("mis_rw",    32'(wb_regwrite), 32'd0);
    chk("mis_reqv",  32'(mem_req_valid), 32'd0);
    chk("mis_stall", 32'(stall), 32'd0);
    step();
    chk("mis_pulse", 32'(exc_misaligned), 32'd0);
    chk("mis_hold",  exc_addr, 32'h0000_0006);

    // Misaligned LH at odd address
    issue(6'h21, 32'h0000_0101, 32'h0, 5'd3, 1'b1);
    chk("mish_exc",  32'(exc_misaligned), 32'd1);
    chk("mish_addr", exc_addr, 32'h0000_0101);

    // Timeout: LW 0x10, no response
    issue(6'h23, 32'h0000_0010, 32'h0, 5'd4, 1'b1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    step(); step(); step();
    chk("to_stall4", 32'(stall), 32'd1);
    chk("to_nobus",  32'(exc_buserr), 32'd0);
    step();
    chk("to_bus",    32'(exc_buserr), 32'd1);
    chk("to_addr",   exc_addr, 32'h0000_0010);
    chk("to_wbv",    32'(wb_valid), 32'd1);
    chk("to_rw",     32'(wb_regwrite), 32'd0);
    chk("to_stall",  32'(stall), 32'd0);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    chk("to_stray_wbv", 32'(wb_valid), 32'd0);
    chk("to_stray_bus", 32'(exc_buserr), 32'd0);

    // Reset while an LHU is waiting
    issue(6'h25, 32'h0000_0102, 32'h0, 5'd9, 1'b1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("rw_stall", 32'(stall), 32'd0);
    chk("rw_wbv",   32'(wb_valid), 32'd0);
    chk("rw_wbd",   wb_data, 32'd0);
    chk("rw_reqv",  32'(mem_req_valid), 32'd0);
    chk("rw_addr",  mem_addr, 32'd0);
    chk("rw_exc",   exc_addr, 32'd0);
    mem_resp_valid = 1'b1; mem_rdata = 32'h80FF_7F01;
    step();
    mem_resp_valid = 1'b0;
    chk("rw_late_wbv",   32'(wb_valid), 32'd0);
    chk("rw_late_stall", 32'(stall), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
